// File: rtl/eth_mac_rx_filt_if.sv
// PHY-side receive signals plus filtered byte stream and per-frame status.
interface eth_mac_rx_filt_if #(
   parameter int DATA_W = 4
) ();
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_er;
   logic [7:0]        data_out;
   logic              wr_en;
   logic              frame_valid;
   logic              frame_err;
   logic [2:0]        err_code;

   modport master (
      output rx_data, rx_valid, rx_er,
      input  data_out, wr_en, frame_valid, frame_err, err_code
   );

   modport slave (
      input  rx_data, rx_valid, rx_er,
      output data_out, wr_en, frame_valid, frame_err, err_code
   );
endinterface

// File: rtl/eth_mac_rx_filt.sv
// Ethernet RX framer/filter: strips preamble and FCS, filters on DA, checks CRC and length.
// Bytes leave 4 strobes late (FCS held back); one status pulse the cycle after rx_valid drops; no backpressure.
module eth_mac_rx_filt #(
   parameter int                    DATA_W       = 4,
   parameter int                    NUM_MAC      = 2,
   parameter logic [48*NUM_MAC-1:0] MAC_TABLE    = '0,
   parameter bit                    ACCEPT_BCAST = 1'b1,
   parameter bit                    PROMISC      = 1'b0,
   parameter int                    MIN_FRAME    = 64,
   parameter int                    MAX_FRAME    = 1518,
   parameter int                    IFG_CYCLES   = 12
) (
   input  logic            rx_clk,
   input  logic            rst_n,
   eth_mac_rx_filt_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_FRAME + 2);
   localparam int IFG_W = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_FRAME);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FRAME);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {IDLE, PREAMBLE, FRAME, DROP, IFG} state_t;

   state_t             state;
   logic               byte_stb;
   logic [7:0]         byte_val;
   logic               nib_phase;
   logic [CNT_W-1:0]   byte_cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [31:0]        crc;
   logic [7:0]         dly [4];
   logic [NUM_MAC-1:0] da_match;
   logic [NUM_MAC-1:0] hit_vec;
   logic               bcast_ok;
   logic               bcast_hit;
   logic               da_pass;
   logic [2:0]         da_sel;
   logic               err_rx;
   logic               err_over;
   logic               err_da;
   logic [IFG_W-1:0]   ifg_cnt;
   logic [7:0]         out_byte;
   logic               out_wr;
   logic               pulse_ok;
   logic               pulse_err;
   logic [2:0]         code;

   assign bus.data_out    = out_byte;
   assign bus.wr_en       = out_wr;
   assign bus.frame_valid = pulse_ok;
   assign bus.frame_err   = pulse_err;
   assign bus.err_code    = code;

   generate
      if (DATA_W == 4) begin : g_mii
         logic [3:0] nib_lo;
         // Phase is forced low whenever the envelope drops so every frame starts on a low nibble.
         always_ff @(posedge rx_clk or negedge rst_n) begin
            if (!rst_n) begin
               nib_phase <= 1'b0;
               nib_lo    <= '0;
            end else if (!bus.rx_valid) begin
               nib_phase <= 1'b0;
            end else begin
               nib_phase <= ~nib_phase;
               if (!nib_phase) nib_lo <= bus.rx_data[3:0];
            end
         end
         always_comb begin
            byte_stb = bus.rx_valid & nib_phase;
            byte_val = {bus.rx_data[3:0], nib_lo};
         end
      end else begin : g_gmii
         assign nib_phase = 1'b0;
         always_comb begin
            byte_stb = bus.rx_valid;
            byte_val = bus.rx_data[7:0];
         end
      end
   endgenerate

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      cnt_next  = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
      da_sel    = (byte_cnt < CNT_W'(6)) ? byte_cnt[2:0] : 3'd0;
      hit_vec   = '0;
      for (int i = 0; i < NUM_MAC; i++)
         hit_vec[i] = da_match[i] && (byte_val == MAC_TABLE[48*i + 8*(5 - int'(da_sel)) +: 8]);
      bcast_hit = bcast_ok && (byte_val == 8'hFF);
      da_pass   = PROMISC || (|hit_vec) || (ACCEPT_BCAST && bcast_hit);
   end

   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         crc       <= '0;
         ifg_cnt   <= '0;
         for (int i = 0; i < 4; i++) dly[i] <= '0;
         da_match  <= '0;
         bcast_ok  <= 1'b0;
         err_rx    <= 1'b0;
         err_over  <= 1'b0;
         err_da    <= 1'b0;
         out_byte  <= '0;
         out_wr    <= 1'b0;
         pulse_ok  <= 1'b0;
         pulse_err <= 1'b0;
         code      <= '0;
      end else begin
         out_wr    <= 1'b0;
         pulse_ok  <= 1'b0;
         pulse_err <= 1'b0;
         code      <= '0;
         case (state)
            IDLE: if (byte_stb && byte_val == 8'h55) state <= PREAMBLE;
            PREAMBLE: begin
               if (!bus.rx_valid) begin
                  state <= IDLE;
               end else if (byte_stb) begin
                  if (byte_val == 8'hD5) begin
                     state    <= FRAME;
                     crc      <= '1;
                     byte_cnt <= '0;
                     da_match <= '1;
                     bcast_ok <= 1'b1;
                     err_rx   <= 1'b0;
                     err_over <= 1'b0;
                     err_da   <= 1'b0;
                  end else if (byte_val != 8'h55) begin
                     state <= IDLE;
                  end
               end
            end
            FRAME, DROP: begin
               if (!bus.rx_valid) begin
                  state   <= IFG;
                  ifg_cnt <= '0;
                  if (err_rx)                   begin pulse_err <= 1'b1; code <= 3'd5; end
                  else if (nib_phase)           begin pulse_err <= 1'b1; code <= 3'd6; end
                  else if (err_over)            begin pulse_err <= 1'b1; code <= 3'd3; end
                  else if (err_da)              begin pulse_err <= 1'b1; code <= 3'd4; end
                  else if (byte_cnt < MIN_C)    begin pulse_err <= 1'b1; code <= 3'd2; end
                  else if (crc != CRC_RESIDUE)  begin pulse_err <= 1'b1; code <= 3'd1; end
                  else                          pulse_ok <= 1'b1;
               end else begin
                  if (bus.rx_er) err_rx <= 1'b1;
                  if (byte_stb) begin
                     crc      <= crc_byte(crc, byte_val);
                     byte_cnt <= cnt_next;
                     if (cnt_next > MAX_C) err_over <= 1'b1;
                     if (byte_cnt < CNT_W'(6)) begin
                        da_match <= hit_vec;
                        bcast_ok <= bcast_hit;
                     end
                  end
                  // The strobe that triggers a drop still releases its delayed byte.
                  if (state == FRAME) begin
                     if (bus.rx_er) begin
                        state <= DROP;
                     end else if (byte_stb) begin
                        dly[0] <= byte_val;
                        dly[1] <= dly[0];
                        dly[2] <= dly[1];
                        dly[3] <= dly[2];
                        if (byte_cnt >= CNT_W'(4)) begin
                           out_wr   <= 1'b1;
                           out_byte <= dly[3];
                        end
                        if (cnt_next > MAX_C) begin
                           state <= DROP;
                        end else if (byte_cnt == CNT_W'(5) && !da_pass) begin
                           err_da <= 1'b1;
                           state  <= DROP;
                        end
                     end
                  end
               end
            end
            IFG: begin
               if (ifg_cnt < IFG_W'(IFG_CYCLES)) ifg_cnt <= ifg_cnt + 1'b1;
               else if (!bus.rx_valid)          state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eth_mac_rx_filt.sv
// Directed bench: MII instance rejecting broadcast, GMII instance accepting it.
module tb_eth_mac_rx_filt;
   localparam int          IFG   = 12;
   localparam logic [47:0] MAC0  = 48'h02_11_22_33_44_55;
   localparam logic [47:0] MAC1  = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] MISS  = 48'h02_11_22_33_44_56;
   localparam logic [95:0] MACS  = {MAC1, MAC0};

   logic rx_clk = 1'b0;
   logic rst_n  = 1'b0;

   eth_mac_rx_filt_if #(.DATA_W(4)) if4 ();
   eth_mac_rx_filt_if #(.DATA_W(8)) if8 ();

   eth_mac_rx_filt #(
      .DATA_W(4), .NUM_MAC(2), .MAC_TABLE(MACS), .ACCEPT_BCAST(1'b0), .PROMISC(1'b0),
      .MIN_FRAME(64), .MAX_FRAME(1518), .IFG_CYCLES(IFG)
   ) dut4 (.rx_clk(rx_clk), .rst_n(rst_n), .bus(if4));

   eth_mac_rx_filt #(
      .DATA_W(8), .NUM_MAC(2), .MAC_TABLE(MACS), .ACCEPT_BCAST(1'b1), .PROMISC(1'b0),
      .MIN_FRAME(64), .MAX_FRAME(1518), .IFG_CYCLES(IFG)
   ) dut8 (.rx_clk(rx_clk), .rst_n(rst_n), .bus(if8));

   always #5 rx_clk = ~rx_clk;

   logic [7:0] cap4[$];
   logic [7:0] cap8[$];
   int fv4 = 0, fe4 = 0, ov4 = 0;
   int fv8 = 0, fe8 = 0, ov8 = 0;
   logic [2:0] code4 = '0, code8 = '0;

   always @(negedge rx_clk) begin
      if (if4.wr_en) cap4.push_back(if4.data_out);
      if (if4.frame_valid) fv4++;
      if (if4.frame_err) begin fe4++; code4 = if4.err_code; end
      if (if4.wr_en && (if4.frame_valid || if4.frame_err)) ov4++;
      if (if8.wr_en) cap8.push_back(if8.data_out);
      if (if8.frame_valid) fv8++;
      if (if8.frame_err) begin fe8++; code8 = if8.err_code; end
      if (if8.wr_en && (if8.frame_valid || if8.frame_err)) ov8++;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] frm[$];

   // Frame body plus FCS, CRC computed MSB-first on bit-reversed bytes.
   task automatic build(input logic [47:0] da, input int len);
      logic [31:0] c;
      logic [31:0] f;
      frm.delete();
      for (int j = 0; j < 6; j++) frm.push_back(8'(da >> (8 * (5 - j))));
      for (int j = 0; j < 6; j++) frm.push_back((j == 0) ? 8'h02 : ((j == 5) ? 8'h01 : 8'h00));
      frm.push_back(8'h08);
      frm.push_back(8'h00);
      for (int i = 14; i < len - 4; i++) frm.push_back(8'(i));
      c = '1;
      for (int i = 0; i < frm.size(); i++) begin
         for (int k = 0; k < 8; k++) c[31-k] = c[31-k] ^ frm[i][k];
         for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      for (int k = 0; k < 32; k++) f[k] = ~c[31-k];
      for (int j = 0; j < 4; j++) frm.push_back(8'(f >> (8 * j)));
   endtask

   task automatic drive(input bit mii, input logic vld, input logic [7:0] d, input logic er);
      @(posedge rx_clk); #1;
      if (mii) begin
         if4.rx_valid = vld; if4.rx_data = d[3:0]; if4.rx_er = er;
      end else begin
         if8.rx_valid = vld; if8.rx_data = d; if8.rx_er = er;
      end
   endtask

   task automatic put(input bit mii, input logic [7:0] b, input logic er);
      if (mii) begin
         drive(1'b1, 1'b1, b, er);
         drive(1'b1, 1'b1, {4'h0, b[7:4]}, 1'b0);
      end else begin
         drive(1'b0, 1'b1, b, er);
      end
   endtask

   task automatic send(input bit mii, input int er_at, input bit odd, input int rst_at);
      repeat (7) put(mii, 8'h55, 1'b0);
      put(mii, 8'hD5, 1'b0);
      for (int i = 0; i < frm.size(); i++) begin
         if (i == rst_at) begin
            drive(mii, 1'b0, 8'h00, 1'b0);
            @(negedge rx_clk); #1 rst_n = 1'b0;
            @(posedge rx_clk); #1 rst_n = 1'b1;
            return;
         end
         put(mii, frm[i], i == er_at);
      end
      if (odd) drive(mii, 1'b1, 8'h0A, 1'b0);
      drive(mii, 1'b0, 8'h00, 1'b0);
   endtask

   int b_wr, b_fv, b_fe;

   task automatic mark(input bit mii);
      b_wr = mii ? cap4.size() : cap8.size();
      b_fv = mii ? fv4 : fv8;
      b_fe = mii ? fe4 : fe8;
   endtask

   task automatic result(input string tag, input bit mii, input int exp_wr, input int exp_fv,
                         input int exp_fe, input int exp_code, input bit cmp);
      int nw;
      repeat (IFG + 8) @(posedge rx_clk);
      nw = (mii ? cap4.size() : cap8.size()) - b_wr;
      chk({tag, "/wr"}, nw, exp_wr);
      chk({tag, "/fv"}, (mii ? fv4 : fv8) - b_fv, exp_fv);
      chk({tag, "/fe"}, (mii ? fe4 : fe8) - b_fe, exp_fe);
      if (exp_fe != 0) chk({tag, "/code"}, mii ? code4 : code8, exp_code);
      if (cmp) begin
         for (int k = 0; k < exp_wr && k < nw; k++) begin
            if (mii) chk($sformatf("%s/byte%0d", tag, k), cap4[b_wr + k], frm[k]);
            else     chk($sformatf("%s/byte%0d", tag, k), cap8[b_wr + k], frm[k]);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      if4.rx_valid = 1'b0; if4.rx_data = '0; if4.rx_er = 1'b0;
      if8.rx_valid = 1'b0; if8.rx_data = '0; if8.rx_er = 1'b0;
      repeat (3) @(posedge rx_clk);
      @(negedge rx_clk);
      chk("rst/wr8",   if8.wr_en, 0);
      chk("rst/fv8",   if8.frame_valid, 0);
      chk("rst/fe8",   if8.frame_err, 0);
      chk("rst/code8", if8.err_code, 0);
      chk("rst/dout8", if8.data_out, 0);
      chk("rst/wr4",   if4.wr_en, 0);
      chk("rst/dout4", if4.data_out, 0);
      @(posedge rx_clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge rx_clk);

      build(MAC0, 64); mark(1); send(1, -1, 0, -1);
      result("mii_good", 1, 60, 1, 0, 0, 1);

      build(BCAST, 64); mark(1); send(1, -1, 0, -1);
      result("mii_bcast_rej", 1, 2, 0, 1, 4, 1);

      build(MISS, 64); mark(1); send(1, -1, 0, -1);
      result("mii_da5_miss", 1, 2, 0, 1, 4, 1);

      build(MAC0, 64); mark(1); send(1, -1, 1, -1);
      result("mii_odd_nib", 1, 60, 0, 1, 6, 0);

      build(MAC1, 1519); mark(0); send(0, -1, 0, -1);
      result("gmii_oversize", 0, 1515, 0, 1, 3, 0);

      build(MAC1, 64); frm[60] = frm[60] ^ 8'h04; mark(0); send(0, -1, 0, -1);
      result("gmii_fcs_bit", 0, 60, 0, 1, 1, 1);

      build(MAC0, 40); mark(0); send(0, -1, 0, -1);
      result("gmii_runt", 0, 36, 0, 1, 2, 1);

      build(MAC0, 64); mark(0); send(0, 20, 0, -1);
      result("gmii_rx_er", 0, 16, 0, 1, 5, 1);

      build(BCAST, 64); mark(0); send(0, -1, 0, -1);
      result("gmii_bcast_ok", 0, 60, 1, 0, 0, 1);

      frm.delete(); frm.push_back(8'h02); frm.push_back(8'h11); frm.push_back(8'h22);
      mark(0); send(0, -1, 0, -1);
      result("gmii_short", 0, 0, 0, 1, 2, 0);

      build(MAC0, 64); mark(0); send(0, -1, 0, 30);
      result("gmii_rst_abort", 0, 26, 0, 0, 0, 1);

      repeat (IFG) @(posedge rx_clk);
      build(MAC0, 64); mark(0); send(0, -1, 0, -1);
      result("gmii_after_rst", 0, 60, 1, 0, 0, 1);

      chk("overlap4", ov4, 0);
      chk("overlap8", ov8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
